car_detector: RTL and testbench

- Conditions the raw inductive-loop sensor and feeds the single-bit `car` request to the downstream traffic light controller.
- Synchronises and debounces the loop, then counts vehicle arrivals in a saturating queue.
- Holds `car` high until every queued vehicle has been served.
- Detects a stuck-occupied loop and forces a fail-safe request.

---
 rtl/car_detector_if.sv | 14 +
 rtl/car_detector.sv | 126 ++++++++++++
 tb/tb_car_detector.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/car_detector_if.sv
// Loop-sensor / traffic-controller signal bundle for the car detector.
interface car_detector_if #(
    parameter int unsigned CNT_W = 3
);
    logic             loop_raw;
    logic             serve;
    logic             car;
    logic [CNT_W-1:0] queue_cnt;
    logic             overflow;
    logic             fault;

    modport master (output loop_raw, serve, input car, queue_cnt, overflow, fault);
    modport slave  (input loop_raw, serve, output car, queue_cnt, overflow, fault);
endinterface

// File: rtl/car_detector.sv
// Synchronises and debounces an inductive loop, queues arrivals and
// raises a request (or fail-safe request when the loop is stuck).
module car_detector #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 1024,
    parameter int unsigned CNT_W        = 3
) (
    input  logic           clock,
    input  logic           reset,
    car_detector_if.slave  bus
);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEB_CYCLES);
    localparam logic [STK_W-1:0] STK_LIM = STK_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // With a one-sample filter the check state accepts whatever follows.
    localparam bit SINGLE = (DEB_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, RISE_CHK, OCCUPIED, FALL_CHK} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             loop_s_q, loop_s_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [STK_W-1:0] stuck_cnt_q, stuck_cnt_d;
    logic [CNT_W-1:0] queue_cnt_q, queue_cnt_d;
    logic             overflow_q, overflow_d;
    logic             fault_q, fault_d;
    logic             car_q, car_d;
    logic             arrive_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            loop_s_q    <= 1'b0;
            deb_cnt_q   <= '0;
            stuck_cnt_q <= '0;
            queue_cnt_q <= '0;
            overflow_q  <= 1'b0;
            fault_q     <= 1'b0;
            car_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            loop_s_q    <= loop_s_d;
            deb_cnt_q   <= deb_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            queue_cnt_q <= queue_cnt_d;
            overflow_q  <= overflow_d;
            fault_q     <= fault_d;
            car_q       <= car_d;
        end
    end

    // Synchroniser, debounce FSM and stuck-loop counter.
    always_comb begin
        sync1_d     = bus.loop_raw;
        loop_s_d    = sync1_q;
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        stuck_cnt_d = stuck_cnt_q;
        arrive_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (loop_s_q) begin
                    state_d   = RISE_CHK;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            RISE_CHK: begin
                if (!loop_s_q && !SINGLE) begin
                    state_d = IDLE;
                end else if (deb_cnt_q >= DEB_LIM) begin
                    state_d  = OCCUPIED;
                    arrive_c = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            OCCUPIED: begin
                if (stuck_cnt_q < STK_LIM) begin
                    stuck_cnt_d = stuck_cnt_q + STK_W'(1);
                end
                if (!loop_s_q) begin
                    state_d   = FALL_CHK;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            FALL_CHK: begin
                if (loop_s_q && !SINGLE) begin
                    state_d = OCCUPIED;
                end else if (deb_cnt_q >= DEB_LIM) begin
                    state_d     = IDLE;
                    stuck_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Vehicle queue; a simultaneous arrival and service cancel out.
    always_comb begin
        queue_cnt_d = queue_cnt_q;
        overflow_d  = overflow_q;
        if (arrive_c && !bus.serve) begin
            if (queue_cnt_q != CNT_MAX) begin
                queue_cnt_d = queue_cnt_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (!arrive_c && bus.serve && (queue_cnt_q != '0)) begin
            queue_cnt_d = queue_cnt_q - CNT_W'(1);
        end
        fault_d = fault_q | (stuck_cnt_d == STK_LIM);
        car_d   = (queue_cnt_d != '0) | fault_d;
    end

    assign bus.car       = car_q;
    assign bus.queue_cnt = queue_cnt_q;
    assign bus.overflow  = overflow_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_car_detector.sv
// Scenario bench for car_detector: a small model pushes expected outputs,
// each scenario pops and compares them when the DUT should have updated.
module tb_car_detector;
    logic clock;
    logic reset;

    car_detector_if #(.CNT_W(3)) bus ();

    car_detector #(.DEB_CYCLES(4), .STUCK_CYCLES(16), .CNT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       car;
        logic [2:0] cnt;
        logic       ovf;
        logic       flt;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [5:0] obs;
    logic [2:0] m_cnt;
    logic       m_ovf;
    logic       m_flt;
    int         errors = 0;
    int         checks = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_model();
        exp_t x;
        x.car = (m_cnt != 3'd0) | m_flt;
        x.cnt = m_cnt;
        x.ovf = m_ovf;
        x.flt = m_flt;
        sb.push_back(x);
    endtask

    task automatic pop_exp();
        if (sb.size() == 0) begin
            e = '0;
            e.flt = 1'bx;
        end else begin
            e = sb.pop_front();
        end
        obs = {bus.car, bus.queue_cnt, bus.overflow, bus.fault};
    endtask

    task automatic model_reset();
        m_cnt = 3'd0;
        m_ovf = 1'b0;
        m_flt = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.loop_raw = 1'b0;
        bus.serve    = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Raw high from now; the queue reflects the arrival 7 edges later.
    task automatic arrive_start(input bit with_serve);
        bus.loop_raw = 1'b1;
        if (!with_serve) begin
            if (m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
            else               m_ovf = 1'b1;
        end
        push_model();
        repeat (6) tick();
        if (with_serve) bus.serve = 1'b1;
        tick();
        bus.serve = 1'b0;
    endtask

    task automatic arrive_finish();
        repeat (3) tick();
        bus.loop_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic serve_pulse();
        bus.serve = 1'b1;
        if (m_cnt != 3'd0) m_cnt = m_cnt - 3'd1;
        push_model();
        tick();
        bus.serve = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.loop_raw = 1'b1;
        bus.serve    = 1'b0;
        model_reset();
        repeat (3) tick();
        push_model();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, e);
        end
        reset = 1'b1;
        m_cnt = 3'd1;
        push_model();
        repeat (6) tick();
        checks++;
        if ({bus.car, bus.queue_cnt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_edge6: got car=%b cnt=%0d expected car=0 cnt=0", bus.car, bus.queue_cnt);
        end
        tick();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_edge7: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int g = 0; g < 5; g++) begin
            bus.loop_raw = 1'b1;
            push_model();
            repeat (3) tick();
            bus.loop_raw = 1'b0;
            repeat (8) tick();
            pop_exp();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL glitch_%0d: got %b expected %b", g, obs, e);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        arrive_start(1'b0);
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL single_arrive: got %b expected %b", obs, e);
        end
        arrive_finish();
        repeat (10) tick();
        push_model();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL single_hold: got %b expected %b", obs, e);
        end
        serve_pulse();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL single_serve: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int v = 0; v < 9; v++) begin
            bit both;
            both = (v == 0) || (v == 4) || (v == 8);
            arrive_start(both);
            pop_exp();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL simul_%0d both=%0d: got %b expected %b", v, both, obs, e);
            end
            arrive_finish();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int v = 0; v < 8; v++) begin
            arrive_start(1'b0);
            pop_exp();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sat_arrive_%0d: got %b expected %b", v, obs, e);
            end
            arrive_finish();
        end
        for (int s = 0; s < 8; s++) begin
            serve_pulse();
            pop_exp();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sat_serve_%0d: got %b expected %b", s, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_stuck();
        do_reset();
        bus.loop_raw = 1'b1;
        m_cnt = 3'd1;
        push_model();
        repeat (7) tick();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL stuck_arrive: got %b expected %b", obs, e);
        end
        push_model();
        repeat (15) tick();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL stuck_before: got %b expected %b", obs, e);
        end
        m_flt = 1'b1;
        push_model();
        tick();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL stuck_fault: got %b expected %b", obs, e);
        end
        serve_pulse();
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL stuck_drain: got %b expected %b", obs, e);
        end
        repeat (5) tick();
        @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
        push_model();
        #1;
        pop_exp();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL stuck_async_reset: got %b expected %b", obs, e);
        end
        bus.loop_raw = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_simultaneous();
        test_saturation();
        test_stuck();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
